// File: rtl/i2c_seq_pkg.sv
// Shared definitions for the I2C register read/write sequencers: state
// encoding, default timer period select and bus-status helpers.
package i2c_seq_pkg;

  localparam int unsigned STATE_W = 4;
  localparam logic [3:0]  TIMER_PARAM_DEFAULT = 4'h1;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE          = 4'd0,
    S_VALIDATE_BUS  = 4'd1,
    S_VALIDATE_WAIT = 4'd2,
    S_ADDR_CMD      = 4'd3,
    S_ADDR_DATA     = 4'd4,
    S_READ_CMD      = 4'd5,
    S_READ_DATA     = 4'd6,
    S_CHECK_FREE    = 4'd7
  } seq_state_e;

  // Bus may be claimed: nobody is driving it and no transfer is in flight.
  function automatic logic bus_valid(input logic busy, input logic active);
    return ~busy & ~active;
  endfunction

  // Bus released after our own transfer.
  function automatic logic bus_free(input logic busy, input logic control);
    return ~busy & ~control;
  endfunction

  function automatic logic is_wait_state(input seq_state_e s);
    return s inside {S_VALIDATE_WAIT, S_ADDR_CMD, S_ADDR_DATA,
                     S_READ_CMD, S_READ_DATA, S_CHECK_FREE};
  endfunction

endpackage

// File: rtl/i2c_read_shift.sv
// Byte shift register with counter: assembles read bytes MSB-first.
module i2c_read_shift #(
  parameter int unsigned NUM_BYTES = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   load,
  input  logic [7:0]             byte_in,
  output logic [8*NUM_BYTES-1:0] word,
  output logic                   final_byte_c
);

  localparam int unsigned WORD_W = 8 * NUM_BYTES;
  localparam int unsigned CNT_W  = $clog2(NUM_BYTES + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word  <= '0;
      count <= '0;
    end else if (clear) begin
      word  <= '0;
      count <= '0;
    end else if (load) begin
      word  <= WORD_W'({word, byte_in});
      count <= count + 1'b1;
    end
  end

  // High when the next load completes the word.
  assign final_byte_c = (count == CNT_W'(NUM_BYTES - 1));

endmodule

// File: rtl/i2c_read_reg.sv
// Register-read sequencer: address write, repeated-start read of NUM_BYTES.
// Timer handshake and timeouts exist only with I2C_READ_REG_TIMEOUT_EN.
module i2c_read_reg
  import i2c_seq_pkg::*;
#(
  parameter int unsigned NUM_BYTES   = 2,
  parameter logic [3:0]  TIMER_PARAM = TIMER_PARAM_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [6:0]             dev_address,
  input  logic [7:0]             reg_address,
  input  logic                   start,
  output logic                   done,
  output logic [8*NUM_BYTES-1:0] data_out,
  output logic                   message_failure,
  input  logic                   timer_exp,
  output logic                   timer_start,
  output logic                   timer_reset,
  output logic [3:0]             timer_param,
  input  logic                   i2c_cmd_ready,
  input  logic                   i2c_data_out_ready,
  input  logic [7:0]             i2c_data_in,
  input  logic                   i2c_data_in_valid,
  input  logic                   i2c_data_in_last,
  input  logic                   i2c_bus_busy,
  input  logic                   i2c_bus_control,
  input  logic                   i2c_bus_active,
  input  logic                   i2c_missed_ack,
  output logic [6:0]             i2c_dev_address,
  output logic [7:0]             i2c_data_out,
  output logic                   i2c_cmd_start,
  output logic                   i2c_cmd_read,
  output logic                   i2c_cmd_write,
  output logic                   i2c_cmd_stop,
  output logic                   i2c_cmd_valid,
  output logic                   i2c_data_out_valid,
  output logic                   i2c_data_out_last,
  output logic                   i2c_data_in_ready,
  output logic [3:0]             state_out
);

  localparam int unsigned WORD_W = 8 * NUM_BYTES;

  seq_state_e        state_q, state_d;
  logic              done_d, fail_d;
  logic              shift_clear, shift_load, final_byte_c;
  logic              timeout_c, bus_valid_c, bus_free_c;
  logic [WORD_W-1:0] shadow_word;
  logic [7:0]        reg_addr_q;

  assign bus_valid_c = bus_valid(i2c_bus_busy, i2c_bus_active);
  assign bus_free_c  = bus_free(i2c_bus_busy, i2c_bus_control);
  assign state_out   = state_q;

`ifdef I2C_READ_REG_TIMEOUT_EN
  logic arm_c;
  assign arm_c     = is_wait_state(state_d) && (state_d != state_q);
  // An expiry seen while re-arming belongs to the previous period.
  assign timeout_c = timer_exp & ~timer_start;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_start <= 1'b0;
      timer_reset <= 1'b0;
      timer_param <= TIMER_PARAM;
    end else begin
      timer_start <= arm_c;
      timer_reset <= arm_c;
      timer_param <= TIMER_PARAM;
    end
  end
`else
  logic unused_timer_exp;
  assign unused_timer_exp = timer_exp;
  assign timeout_c        = 1'b0;
  assign timer_start      = 1'b0;
  assign timer_reset      = 1'b0;
  assign timer_param      = 4'h0;
`endif

  i2c_read_shift #(.NUM_BYTES(NUM_BYTES)) u_shift (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (shift_clear),
    .load         (shift_load),
    .byte_in      (i2c_data_in),
    .word         (shadow_word),
    .final_byte_c (final_byte_c)
  );

  // Next-state and pulse decode.
  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    fail_d      = 1'b0;
    shift_clear = 1'b0;
    shift_load  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_VALIDATE_BUS;
          shift_clear = 1'b1;
        end
      end
      S_VALIDATE_BUS: state_d = bus_valid_c ? S_ADDR_CMD : S_VALIDATE_WAIT;
      S_VALIDATE_WAIT: begin
        if (bus_valid_c)    state_d = S_ADDR_CMD;
        else if (timeout_c) begin state_d = S_IDLE; fail_d = 1'b1; end
      end
      S_ADDR_CMD: begin
        if (i2c_cmd_ready)  state_d = S_ADDR_DATA;
        else if (timeout_c) begin state_d = S_IDLE; fail_d = 1'b1; end
      end
      S_ADDR_DATA: begin
        if (i2c_data_out_ready) state_d = S_READ_CMD;
        else if (timeout_c)     begin state_d = S_IDLE; fail_d = 1'b1; end
      end
      S_READ_CMD: begin
        if (i2c_cmd_ready)  state_d = S_READ_DATA;
        else if (timeout_c) begin state_d = S_IDLE; fail_d = 1'b1; end
      end
      S_READ_DATA: begin
        if (i2c_data_in_valid) begin
          shift_load = 1'b1;
          if (final_byte_c)          state_d = S_CHECK_FREE;
          else if (i2c_data_in_last) begin state_d = S_IDLE; fail_d = 1'b1; end
        end else if (timeout_c) begin
          state_d = S_IDLE;
          fail_d  = 1'b1;
        end
      end
      S_CHECK_FREE: begin
        if (bus_free_c)     begin state_d = S_IDLE; done_d = 1'b1; end
        else if (timeout_c) begin state_d = S_IDLE; fail_d = 1'b1; end
      end
      default: state_d = S_IDLE;
    endcase
    // Missed ACK aborts from anywhere outside idle.
    if (state_q != S_IDLE && i2c_missed_ack) begin
      state_d    = S_IDLE;
      fail_d     = 1'b1;
      done_d     = 1'b0;
      shift_load = 1'b0;
    end
  end

  // State and registered bus outputs, decoded from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q            <= S_IDLE;
      done               <= 1'b0;
      message_failure    <= 1'b0;
      data_out           <= '0;
      reg_addr_q         <= '0;
      i2c_dev_address    <= '0;
      i2c_data_out       <= '0;
      i2c_cmd_start      <= 1'b0;
      i2c_cmd_read       <= 1'b0;
      i2c_cmd_write      <= 1'b0;
      i2c_cmd_stop       <= 1'b0;
      i2c_cmd_valid      <= 1'b0;
      i2c_data_out_valid <= 1'b0;
      i2c_data_out_last  <= 1'b0;
      i2c_data_in_ready  <= 1'b0;
    end else begin
      state_q            <= state_d;
      done               <= done_d;
      message_failure    <= fail_d;
      if (done_d) data_out <= shadow_word;
      if (state_q == S_IDLE && start) begin
        i2c_dev_address <= dev_address;
        reg_addr_q      <= reg_address;
      end
      i2c_cmd_valid      <= (state_d == S_ADDR_CMD) || (state_d == S_READ_CMD);
      i2c_cmd_start      <= (state_d == S_ADDR_CMD) || (state_d == S_READ_CMD);
      i2c_cmd_write      <= (state_d == S_ADDR_CMD);
      i2c_cmd_read       <= (state_d == S_READ_CMD);
      i2c_cmd_stop       <= (state_d == S_READ_CMD);
      i2c_data_out_valid <= (state_d == S_ADDR_DATA);
      i2c_data_out_last  <= (state_d == S_ADDR_DATA);
      i2c_data_out       <= (state_d == S_ADDR_DATA) ? reg_addr_q : 8'h00;
      i2c_data_in_ready  <= (state_d == S_READ_DATA);
    end
  end

endmodule

// File: tb/tb_i2c_read_reg.sv
// Scoreboard bench for i2c_read_reg with a reactive I2C master model.
module tb_i2c_read_reg;
  import i2c_seq_pkg::*;

  localparam int NB      = 2;
  localparam int WW      = 8 * NB;
  localparam int LAT     = 5 + NB;
  localparam int MAX_CYC = 300;
  localparam int M_NORMAL = 0, M_ACK = 1, M_EARLY = 2, M_BUSY = 3, M_RST = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [6:0]    dev_address = '0;
  logic [7:0]    reg_address = '0;
  logic          start = 1'b0;
  logic          done, message_failure;
  logic [WW-1:0] data_out;
  logic          timer_exp = 1'b0;
  logic          timer_start, timer_reset;
  logic [3:0]    timer_param;
  logic          i2c_cmd_ready = 1'b0;
  logic          i2c_data_out_ready = 1'b0;
  logic [7:0]    i2c_data_in = '0;
  logic          i2c_data_in_valid = 1'b0;
  logic          i2c_data_in_last = 1'b0;
  logic          i2c_bus_busy = 1'b0;
  logic          i2c_bus_control = 1'b0;
  logic          i2c_bus_active = 1'b0;
  logic          i2c_missed_ack = 1'b0;
  logic [6:0]    i2c_dev_address;
  logic [7:0]    i2c_data_out;
  logic          i2c_cmd_start, i2c_cmd_read, i2c_cmd_write, i2c_cmd_stop, i2c_cmd_valid;
  logic          i2c_data_out_valid, i2c_data_out_last, i2c_data_in_ready;
  logic [3:0]    state_out;

  i2c_read_reg #(.NUM_BYTES(NB), .TIMER_PARAM(4'h1)) dut (
    .clk(clk), .reset_n(reset_n), .dev_address(dev_address), .reg_address(reg_address),
    .start(start), .done(done), .data_out(data_out), .message_failure(message_failure),
    .timer_exp(timer_exp), .timer_start(timer_start), .timer_reset(timer_reset),
    .timer_param(timer_param), .i2c_cmd_ready(i2c_cmd_ready),
    .i2c_data_out_ready(i2c_data_out_ready), .i2c_data_in(i2c_data_in),
    .i2c_data_in_valid(i2c_data_in_valid), .i2c_data_in_last(i2c_data_in_last),
    .i2c_bus_busy(i2c_bus_busy), .i2c_bus_control(i2c_bus_control),
    .i2c_bus_active(i2c_bus_active), .i2c_missed_ack(i2c_missed_ack),
    .i2c_dev_address(i2c_dev_address), .i2c_data_out(i2c_data_out),
    .i2c_cmd_start(i2c_cmd_start), .i2c_cmd_read(i2c_cmd_read),
    .i2c_cmd_write(i2c_cmd_write), .i2c_cmd_stop(i2c_cmd_stop),
    .i2c_cmd_valid(i2c_cmd_valid), .i2c_data_out_valid(i2c_data_out_valid),
    .i2c_data_out_last(i2c_data_out_last), .i2c_data_in_ready(i2c_data_in_ready),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic is_done; logic [WW-1:0] data; } exp_t;
  exp_t sb_q[$];
  int errors = 0;
  int checks = 0;
  logic [WW-1:0] last_good = '0;

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endfunction

  task automatic expect_result(input logic ok, input logic [WW-1:0] w);
    exp_t e;
    e.is_done = ok;
    e.data    = w;
    sb_q.push_back(e);
  endtask

  // Master model configuration and state.
  int         cmd_dly = 0, dat_dly = 0, rd_gap = 0;
  int         cmd_cnt = 0, dat_cnt = 0, gap_cnt = 0, rd_idx = 0, last_at = NB - 1;
  logic [7:0] rd_bytes [NB];
  logic [6:0] cur_dev = '0;
  logic [7:0] cur_reg = '0;
  logic       xfer_seen = 1'b0;
  logic       cmd_stall = 1'b0, dat_stall = 1'b0;
  logic [3:0] cmd_snap = '0;
  logic [7:0] dat_snap = '0;

  always @(posedge clk) xfer_seen <= i2c_data_in_valid & i2c_data_in_ready;

  always @(negedge clk) begin
    if (cmd_stall && !message_failure) begin
      check("cmd_hold_valid", 32'(i2c_cmd_valid), 32'd1);
      check("cmd_hold_bits", 32'({i2c_cmd_start, i2c_cmd_read, i2c_cmd_write, i2c_cmd_stop}), 32'(cmd_snap));
    end
    if (dat_stall && !message_failure) begin
      check("dout_hold_valid", 32'(i2c_data_out_valid), 32'd1);
      check("dout_hold_data", 32'(i2c_data_out), 32'(dat_snap));
    end
    if (i2c_cmd_valid) begin
      if (cmd_cnt >= cmd_dly) begin
        if (!i2c_cmd_ready) begin
          if (i2c_cmd_read)
            check("rd_cmd_bits", 32'({i2c_cmd_start, i2c_cmd_read, i2c_cmd_write, i2c_cmd_stop}), 32'b1101);
          else begin
            check("wr_cmd_bits", 32'({i2c_cmd_start, i2c_cmd_read, i2c_cmd_write, i2c_cmd_stop}), 32'b1010);
            check("dev_address", 32'(i2c_dev_address), 32'(cur_dev));
          end
        end
        i2c_cmd_ready = 1'b1;
      end else begin
        i2c_cmd_ready = 1'b0;
        cmd_cnt++;
      end
    end else begin
      i2c_cmd_ready = 1'b0;
      cmd_cnt = 0;
    end
    cmd_stall = i2c_cmd_valid && !i2c_cmd_ready;
    cmd_snap  = {i2c_cmd_start, i2c_cmd_read, i2c_cmd_write, i2c_cmd_stop};
    if (i2c_data_out_valid) begin
      if (dat_cnt >= dat_dly) begin
        if (!i2c_data_out_ready) begin
          check("reg_address", 32'(i2c_data_out), 32'(cur_reg));
          check("dout_last", 32'(i2c_data_out_last), 32'd1);
        end
        i2c_data_out_ready = 1'b1;
      end else begin
        i2c_data_out_ready = 1'b0;
        dat_cnt++;
      end
    end else begin
      i2c_data_out_ready = 1'b0;
      dat_cnt = 0;
    end
    dat_stall = i2c_data_out_valid && !i2c_data_out_ready;
    dat_snap  = i2c_data_out;
    if (xfer_seen) begin
      rd_idx++;
      gap_cnt = 0;
    end
    if (i2c_data_in_ready && rd_idx < NB) begin
      if (gap_cnt >= rd_gap) begin
        i2c_data_in_valid = 1'b1;
        i2c_data_in       = rd_bytes[rd_idx];
        i2c_data_in_last  = (rd_idx == last_at);
      end else begin
        i2c_data_in_valid = 1'b0;
        gap_cnt++;
      end
    end else begin
      i2c_data_in_valid = 1'b0;
      i2c_data_in       = '0;
      i2c_data_in_last  = 1'b0;
    end
  end

`ifdef I2C_READ_REG_TIMEOUT_EN
  int tcnt = 0;
  always @(negedge clk) begin
    if (timer_start) begin
      tcnt = 40;
      timer_exp = 1'b0;
    end else if (tcnt > 0) begin
      tcnt--;
      timer_exp = (tcnt == 0);
    end else timer_exp = 1'b0;
  end
`endif

  // Result monitor: pops one expectation per done/failure pulse.
  logic prev_pulse = 1'b0;
  always @(negedge clk) begin
    if (prev_pulse) check("pulse_width", 32'(done | message_failure), 32'd0);
    if (reset_n && (done || message_failure)) begin
      check("pulse_exclusive", 32'(done & message_failure), 32'd0);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: done=%0b failure=%0b with nothing expected", done, message_failure);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result_kind_done", 32'(done), 32'(e.is_done));
        check("data_out", 32'(data_out), 32'(e.data));
      end
    end
    prev_pulse = done | message_failure;
  end

  task automatic run_txn(input logic [6:0] dev, input logic [7:0] rg, input logic [WW-1:0] word,
                         input int cdly, input int ddly, input int gap, input int mode);
    int cyc;
    bit injected, busy_cmd;
    cur_dev = dev; cur_reg = rg;
    cmd_dly = cdly; dat_dly = ddly; rd_gap = gap;
    rd_idx = 0; gap_cnt = 0;
    for (int i = 0; i < NB; i++) rd_bytes[i] = word[WW-1-8*i -: 8];
    last_at = (mode == M_EARLY) ? 0 : NB - 1;
    case (mode)
      M_NORMAL: begin expect_result(1'b1, word); last_good = word; end
`ifdef I2C_READ_REG_TIMEOUT_EN
      M_BUSY: expect_result(1'b0, last_good);
`else
      M_BUSY: begin expect_result(1'b1, word); last_good = word; end
`endif
      M_ACK, M_EARLY: expect_result(1'b0, last_good);
      default: ;
    endcase
    if (mode == M_BUSY) i2c_bus_busy = 1'b1;
    @(negedge clk);
    dev_address = dev; reg_address = rg; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; dev_address = 7'($urandom); reg_address = 8'($urandom);
    cyc = 0; injected = 0; busy_cmd = 0;
    while (cyc < MAX_CYC) begin
      if (done || message_failure) break;
      if (mode == M_ACK && !injected && state_out == S_READ_CMD) begin
        i2c_missed_ack = 1'b1;
        injected = 1;
      end
      if (mode == M_BUSY) begin
        if (i2c_bus_busy && i2c_cmd_valid) busy_cmd = 1;
`ifndef I2C_READ_REG_TIMEOUT_EN
        if (cyc == 15) i2c_bus_busy = 1'b0;
`endif
      end
      if (mode == M_RST && !injected && state_out == S_READ_DATA) begin
        injected = 1;
        #2 reset_n = 1'b0;
        #1;
        check("rst_done", 32'(done), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_data_in_ready", 32'(i2c_data_in_ready), 32'd0);
        check("rst_cmd_valid", 32'(i2c_cmd_valid), 32'd0);
        check("rst_state", 32'(state_out), 32'(S_IDLE));
        check("rst_dev_address", 32'(i2c_dev_address), 32'd0);
        last_good = '0;
        @(negedge clk);
        reset_n = 1'b1;
        break;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    i2c_missed_ack = 1'b0;
    i2c_bus_busy   = 1'b0;
    if (cyc >= MAX_CYC) begin
      checks++;
      errors++;
      $display("FAIL txn_timeout: no done/failure after %0d cycles (mode %0d)", cyc, mode);
    end
    if (mode == M_NORMAL && cdly == 0 && ddly == 0 && gap == 0) check("latency", 32'(cyc), 32'(LAT));
    if (mode == M_ACK) begin
      check("ack_injected", 32'(injected), 32'd1);
      check("ack_cmd_valid_low", 32'(i2c_cmd_valid), 32'd0);
    end
    if (mode == M_BUSY) check("busy_no_cmd", 32'(busy_cmd), 32'd0);
    if (mode == M_RST) check("rst_injected", 32'(injected), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_done", 32'(done), 32'd0);
    check("reset_failure", 32'(message_failure), 32'd0);
    check("reset_data_out", 32'(data_out), 32'd0);
    check("reset_cmd_valid", 32'(i2c_cmd_valid), 32'd0);
    check("reset_dout_valid", 32'(i2c_data_out_valid), 32'd0);
    check("reset_din_ready", 32'(i2c_data_in_ready), 32'd0);
    check("reset_timer_start", 32'(timer_start), 32'd0);
`ifdef I2C_READ_REG_TIMEOUT_EN
    check("reset_timer_param", 32'(timer_param), 32'h1);
`else
    check("reset_timer_param", 32'(timer_param), 32'h0);
`endif
    check("reset_state", 32'(state_out), 32'(S_IDLE));
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_txn(7'h21, 8'h0F, 16'hABCD, 0, 0, 0, M_NORMAL);
    run_txn(7'h21, 8'h10, 16'h1234, 0, 0, 0, M_ACK);
    run_txn(7'h35, 8'h22, 16'h5A5A, 10, 0, 0, M_NORMAL);
    run_txn(7'h35, 8'h23, 16'h9999, 0, 0, 0, M_EARLY);
    run_txn(7'h44, 8'h01, 16'h0F0E, 0, 0, 0, M_BUSY);
    run_txn(7'h12, 8'h7E, 16'hFEED, 0, 0, 6, M_RST);
    run_txn(7'h12, 8'h7F, 16'hBEEF, 0, 0, 0, M_NORMAL);
    for (int t = 0; t < 24; t++) begin
      int r;
      int mode;
      r = $urandom_range(0, 5);
      mode = (r == 3) ? M_ACK : (r == 4) ? M_EARLY : M_NORMAL;
      run_txn(7'($urandom), 8'($urandom), WW'($urandom), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 2), mode);
    end
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
